// File: rtl/ad9914_timing_gen.sv
// ad9914_timing_gen
// Burst timing generator for the AD9914 strobe set. A start pulse latches and
// sanitises a burst configuration, fires the profile/CT update strobes, then
// plays N pulse-repetition periods of pre-trigger followed by sweep trigger.
// Every output is a register fed from next-state values, so inputs never reach
// an output combinationally.
module ad9914_timing_gen #(
    parameter int UPD_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] prt_cycles,
    input  logic [15:0] pre_lead,
    input  logic [31:0] trig_high,
    input  logic [15:0] pulse_count,
    input  logic        ct_req,
    input  logic [31:0] ct_period_in,
    output logic        ad9914_update_1,
    output logic        ad9914_update_2,
    output logic        ad9914_pre_trig_1,
    output logic        ad9914_trig_1,
    output logic [31:0] ct_period,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, CFG, UPDATE, RUN} state_t;

    localparam logic [4:0]  UPD_LAST = 5'(UPD_W - 1);
    localparam logic [31:0] UPD_LEN  = 32'(UPD_W);

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [15:0] idx, idx_nxt;
    logic [4:0]  upd_cnt, upd_cnt_nxt;
    logic        done_nxt;

    logic [31:0] prt_l, trig_l;
    logic [15:0] pre_l, count_l;
    logic        ct_req_l;
    logic        accept;

    logic [15:0] pl_v;
    logic [32:0] p_v, thm_v, room_v, th_v;
    logic [15:0] pl;
    logic [32:0] p, th;
    logic [32:0] trig_end;

    logic upd1_nxt, upd2_nxt, pre_nxt, trig_nxt, busy_nxt;

    assign accept = (state == IDLE) && start && !abort;

    // Capture the raw burst configuration and CT period when a start is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            prt_l     <= '0;
            pre_l     <= '0;
            trig_l    <= '0;
            count_l   <= '0;
            ct_req_l  <= 1'b0;
            ct_period <= '0;
        end else if (accept) begin
            prt_l     <= prt_cycles;
            pre_l     <= pre_lead;
            trig_l    <= trig_high;
            count_l   <= pulse_count;
            ct_req_l  <= ct_req;
            ct_period <= ct_period_in;
        end
    end

    // Clamp lead, period and trigger width so the pulse shape is always legal
    always_comb begin
        pl_v   = (pre_l < 16'd24) ? 16'd24 : pre_l;
        p_v    = ({1'b0, prt_l} < ({17'd0, pl_v} + 33'd2)) ? ({17'd0, pl_v} + 33'd2)
                                                            : {1'b0, prt_l};
        thm_v  = (trig_l == 32'd0) ? 33'd1 : {1'b0, trig_l};
        room_v = p_v - {17'd0, pl_v} - 33'd1;
        th_v   = (thm_v < room_v) ? thm_v : room_v;
    end

    // Register the sanitised values during the single CFG cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pl <= '0;
            p  <= '0;
            th <= '0;
        end else if (state == CFG) begin
            pl <= pl_v;
            p  <= p_v;
            th <= th_v;
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= '0;
            idx     <= '0;
            upd_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            idx     <= idx_nxt;
            upd_cnt <= upd_cnt_nxt;
        end
    end

    // Next-state logic: sequencing through update, periods and completion
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        idx_nxt     = idx;
        upd_cnt_nxt = upd_cnt;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = CFG;
                end
            end
            CFG: begin
                state_nxt   = UPDATE;
                upd_cnt_nxt = '0;
            end
            UPDATE: begin
                if (upd_cnt == UPD_LAST) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                    idx_nxt   = '0;
                end else begin
                    upd_cnt_nxt = upd_cnt + 5'd1;
                end
            end
            RUN: begin
                if ({1'b0, pc} == (p - 33'd1)) begin
                    idx_nxt = idx + 16'd1;
                    pc_nxt  = '0;
                    if ((count_l != 16'd0) && (idx_nxt == count_l)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    pc_nxt = pc + 32'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort && (state != IDLE)) begin
            state_nxt   = IDLE;
            done_nxt    = 1'b0;
            pc_nxt      = '0;
            idx_nxt     = '0;
            upd_cnt_nxt = '0;
        end
    end

    // Output decode from the upcoming state so the strobes land in their own cycle
    always_comb begin
        trig_end = {17'd0, pl} + th;
        busy_nxt = (state_nxt != IDLE);
        upd1_nxt = (state_nxt == UPDATE);
        upd2_nxt = (state_nxt == UPDATE) && ct_req_l;
        pre_nxt  = (state_nxt == RUN) && (pc_nxt < UPD_LEN);
        trig_nxt = (state_nxt == RUN) && ({1'b0, pc_nxt} >= {17'd0, pl})
                   && ({1'b0, pc_nxt} < trig_end);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ad9914_update_1   <= 1'b0;
            ad9914_update_2   <= 1'b0;
            ad9914_pre_trig_1 <= 1'b0;
            ad9914_trig_1     <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            ad9914_update_1   <= upd1_nxt;
            ad9914_update_2   <= upd2_nxt;
            ad9914_pre_trig_1 <= pre_nxt;
            ad9914_trig_1     <= trig_nxt;
            busy              <= busy_nxt;
            done              <= done_nxt;
        end
    end

endmodule

// File: tb/tb_ad9914_timing_gen.sv
// tb_ad9914_timing_gen
// Scoreboard bench: each burst pushes its expected per-cycle output vector,
// built from the closed-form timing equations, and a negedge monitor pops and
// compares whenever the DUT reaches that cycle.
module tb_ad9914_timing_gen;

    localparam int W = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] prt_cycles;
    logic [15:0] pre_lead;
    logic [31:0] trig_high;
    logic [15:0] pulse_count;
    logic        ct_req;
    logic [31:0] ct_period_in;
    logic        ad9914_update_1;
    logic        ad9914_update_2;
    logic        ad9914_pre_trig_1;
    logic        ad9914_trig_1;
    logic [31:0] ct_period;
    logic        busy;
    logic        done;

    ad9914_timing_gen #(.UPD_W(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .prt_cycles        (prt_cycles),
        .pre_lead          (pre_lead),
        .trig_high         (trig_high),
        .pulse_count       (pulse_count),
        .ct_req            (ct_req),
        .ct_period_in      (ct_period_in),
        .ad9914_update_1   (ad9914_update_1),
        .ad9914_update_2   (ad9914_update_2),
        .ad9914_pre_trig_1 (ad9914_pre_trig_1),
        .ad9914_trig_1     (ad9914_trig_1),
        .ct_period         (ct_period),
        .busy              (busy),
        .done              (done)
    );

    typedef struct {
        int          cyc;
        logic [37:0] vec;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;
    string       phase = "reset";

    longint      e_pl, e_p, e_th, e_n;
    logic        e_ct;
    logic [31:0] exp_ct = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index used to line up scoreboard entries with DUT outputs
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [37:0] observed,
                               input logic [37:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, observed, expected);
        end
    endtask

    // Monitor: pop every entry due at this cycle and compare
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            sb_entry_t e;
            e = sb.pop_front();
            checkOutput(phase, {ct_period, ad9914_update_1, ad9914_update_2,
                                ad9914_pre_trig_1, ad9914_trig_1, busy, done}, e.vec);
        end
    end

    task automatic setEff(input longint prt, input longint pre, input longint trig,
                          input longint cnt, input logic ct);
        longint thm;
        e_pl = (pre < 24) ? 24 : pre;
        e_p  = (prt < e_pl + 2) ? e_pl + 2 : prt;
        thm  = (trig == 0) ? 1 : trig;
        e_th = (thm < e_p - e_pl - 1) ? thm : e_p - e_pl - 1;
        e_n  = cnt;
        e_ct = ct;
    endtask

    // {upd1, upd2, pre, trig, busy, done} expected at offset o from the start cycle
    function automatic logic [5:0] expVec(input longint o);
        longint r, n, pc;
        if (o == 1) return 6'b000010;
        if (o <= 1 + W) return {1'b1, e_ct, 4'b0010};
        r  = o - (2 + W);
        n  = r / e_p;
        pc = r % e_p;
        if (e_n != 0 && n >= e_n) return (n == e_n && pc == 0) ? 6'b000001 : 6'b000000;
        return {2'b00, (pc < W), (pc >= e_pl && pc < e_pl + e_th), 1'b1, 1'b0};
    endfunction

    task automatic pushBurst(input int k, input int last);
        for (int o = 1; o <= last; o++) begin
            sb.push_back('{cyc: k + o, vec: {exp_ct, expVec(o)}});
        end
    endtask

    task automatic pushIdle(input int from, input int upto);
        for (int c = from; c <= upto; c++) begin
            sb.push_back('{cyc: c, vec: {exp_ct, 6'b000000}});
        end
    endtask

    task automatic truncateAfter(input int m);
        while (sb.size() > 0 && sb[$].cyc > m) void'(sb.pop_back());
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain();
        int budget = 0;
        while (sb.size() > 0 && budget < 100000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (sb.size() != 0) checkOutput("drain_timeout", 38'(sb.size()), 38'd0);
    endtask

    // Drive one start pulse and push the expected burst; limit=0 means whole burst
    task automatic applyStimulus(input logic [31:0] prt, input logic [15:0] pre,
                                 input logic [31:0] trig, input logic [15:0] cnt,
                                 input logic ct, input logic [31:0] ctin,
                                 input int limit, output int k);
        int last;
        prt_cycles   = prt;
        pre_lead     = pre;
        trig_high    = trig;
        pulse_count  = cnt;
        ct_req       = ct;
        ct_period_in = ctin;
        start        = 1'b1;
        k            = cyc;
        setEff(prt, pre, trig, cnt, ct);
        exp_ct = ctin;
        last = (limit > 0) ? limit : int'(2 + W + e_n * e_p);
        pushBurst(k, last);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic doAbort();
        int m;
        abort = 1'b1;
        m = cyc;
        truncateAfter(m);
        pushIdle(m + 1, m + 4);
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic doReset();
        int m;
        rst = 1'b1;
        m = cyc;
        truncateAfter(m);
        exp_ct = 32'd0;
        pushIdle(m + 1, m + 3);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int k, k2;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        prt_cycles = '0; pre_lead = '0; trig_high = '0;
        pulse_count = '0; ct_req = 1'b0; ct_period_in = '0;

        // Reset with random inputs, then idle after release
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            start = 1'($urandom); abort = 1'($urandom);
            prt_cycles = $urandom; pre_lead = 16'($urandom);
            trig_high = $urandom; pulse_count = 16'($urandom);
            ct_req = 1'($urandom); ct_period_in = $urandom;
            pushIdle(cyc, cyc);
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        pushIdle(cyc + 1, cyc + 2);
        waitDrain();

        phase = "basic";
        applyStimulus(32'd100, 16'd30, 32'd40, 16'd3, 1'b1, 32'h1234, 0, k);
        waitDrain();

        phase = "start_abort_idle";
        start = 1'b1; abort = 1'b1;
        pushIdle(cyc + 1, cyc + 4);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        waitDrain();

        phase = "start_while_busy";
        applyStimulus(32'd100, 16'd30, 32'd40, 16'd3, 1'b0, 32'h0000_abcd, 0, k);
        waitUntil(k + 50);
        start = 1'b1; prt_cycles = 32'd500; pulse_count = 16'd1; ct_period_in = 32'hdead;
        @(posedge clk); #1;
        start = 1'b0;
        waitDrain();

        phase = "clamp_restart";
        applyStimulus(32'd20, 16'd5, 32'd100, 16'd2, 1'b0, 32'h55, 0, k);
        waitUntil(k + 2 + W + 52);
        applyStimulus(32'd20, 16'd5, 32'd100, 16'd2, 1'b1, 32'h66, 0, k2);
        waitDrain();

        phase = "reset_in_update";
        applyStimulus(32'd100, 16'd30, 32'd40, 16'd3, 1'b1, 32'h77, 0, k);
        waitUntil(k + 3);
        doReset();
        waitDrain();

        phase = "reset_in_trigger";
        applyStimulus(32'd100, 16'd30, 32'd40, 16'd3, 1'b1, 32'h88, 0, k);
        waitUntil(k + 2 + W + 35);
        doReset();
        waitDrain();

        phase = "basic_after_reset";
        applyStimulus(32'd100, 16'd30, 32'd40, 16'd3, 1'b1, 32'h1234, 0, k);
        waitDrain();

        phase = "continuous_abort";
        applyStimulus(32'd30, 16'd24, 32'd3, 16'd0, 1'b0, 32'h99, 2 + W + 999 * 30 + 25, k);
        waitUntil(k + 2 + W + 999 * 30 + 25);
        doAbort();
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
